lsu_mem_stage: RTL
==================

LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i input 1 (rising edge); rst_i input 1 (sync, active-high).
REQ-002 The block SHALL have these execute-side inputs: addr_i in 32 (ALU result / effective address); store_data_i in 32 (rs2 value); rd_i in 5; funct3_i in 3 (access width/sign); mem_read_i in 1; mem_write_i in 1; mem_to_reg_i in 1; reg_write_i in 1.
REQ-003 The block SHALL have these data-bus ports: dbus_req_o out 1; dbus_we_o out 1; dbus_addr_o out 32 (word aligned, [1:0]=0); dbus_wdata_o out 32; dbus_be_o out 4; dbus_gnt_i in 1 (request accepted); dbus_rvalid_i in 1 (read data valid); dbus_rdata_i in 32.
REQ-004 The block SHALL have these pipeline-control and write-back outputs: stall_o out 1 (freeze upstream); misalign_o out 1 (registered exception pulse); wb_data_o out 32; rd_o out 5; reg_write_o out 1 (all registered).

Function
REQ-005 FSM states SHALL be IDLE, REQ and WAIT_R.
REQ-006 A load is mem_read_i=1; a store is mem_write_i=1 and mem_read_i=0. Both asserted SHALL be handled as a load.
REQ-007 Illegal access: LH/LHU/SH (funct3 x01) with addr_i[0]=1; LW/SW (x10) with addr_i[1:0]!=0; funct3 011, 110 or 111. An illegal access SHALL issue no bus request, SHALL set misalign_o=1 for one cycle and SHALL force reg_write_o=0, with no stall.
REQ-008 dbus_req_o SHALL be asserted combinationally in IDLE for a legal memory op, and in REQ. It SHALL stay high, with addr/we/wdata/be stable, until the cycle dbus_gnt_i=1.
REQ-009 Store completion: IDLE/REQ with gnt=1 SHALL return to IDLE. Store without gnt SHALL go to REQ.
REQ-010 Load: gnt=1 SHALL go to WAIT_R. WAIT_R with dbus_rvalid_i=1 SHALL complete the load and go to IDLE. dbus_rvalid_i outside WAIT_R SHALL be ignored.
REQ-011 stall_o SHALL be combinational: 1 for a pending legal memory op until its completing cycle (store: gnt cycle; load: rvalid cycle), otherwise 0. Upstream holds inputs stable while stall_o=1.
REQ-012 Store byte enables: SB be=0001<<addr[1:0] with wdata = byte replicated x4. SH be=0011<<addr[1] x2 with wdata = halfword replicated x2. SW be=1111 with wdata=store_data_i.
REQ-013 Load extraction from dbus_rdata_i: select byte/half by addr_i[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-014 The write-back register SHALL update every cycle stall_o=0, as follows:
- Completing load: wb_data_o=extracted data.
- Non-load: wb_data_o=addr_i.
- rd_o=rd_i.
- reg_write_o=reg_write_i and not illegal.
REQ-015 While stall_o=1 the write-back register SHALL emit a bubble (reg_write_o=0; wb_data_o and rd_o hold).
REQ-016 Stores and non-memory ops SHALL present write-back one cycle after acceptance. A load SHALL present it one cycle after the rvalid cycle.
REQ-017 The block SHALL be non-pipelined: at most one outstanding bus transaction, and no new request until the prior one completes.

Reset
REQ-018 rst_i=1 SHALL, at the clock edge, force state IDLE and all registered outputs to 0: wb_data_o=0, rd_o=0, reg_write_o=0, misalign_o=0.
REQ-019 While rst_i=1, dbus_req_o and stall_o SHALL be 0 regardless of inputs.
REQ-020 Reset mid-transaction (REQ or WAIT_R) SHALL abandon the transaction; a late dbus_rvalid_i after reset SHALL be ignored.

Verification
REQ-021 LB, addr=0x1003, rdata=0x80FF_FF7F:
- gnt same cycle, rvalid one cycle later -> wb_data_o=0xFFFF_FF80, reg_write_o=1 one cycle after rvalid.
- stall_o=1 for exactly 1 cycle (gnt cycle).
REQ-022 SH, addr=0x2002, store_data=0x1234_ABCD, gnt delayed 3 cycles -> dbus_be_o=1100 and dbus_wdata_o=0xABCD_ABCD held 4 cycles; stall_o=1 for 3 cycles.
REQ-023 LW, addr=0x0000_0006 -> no dbus_req_o, misalign_o=1 next cycle, reg_write_o=0, stall_o=0.
REQ-024 LHU, addr=0x10, rdata=0x0000_9ABC, rvalid 5 cycles after gnt -> wb_data_o=0x0000_9ABC; bubbles (reg_write_o=0) while stalled.
REQ-025 ALU op (mem_read=mem_write=0), addr_i=0xDEAD_BEEF, rd=5, reg_write=1 -> next cycle wb_data_o=0xDEAD_BEEF, rd_o=5, reg_write_o=1, no bus activity.
REQ-026 Load in WAIT_R, assert rst_i one cycle, then pulse rvalid -> state IDLE, all outputs 0, the rvalid pulse produces no write-back.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: issues one data-bus transaction at a time,
// formats store lanes, extracts load data and registers write-back.
module lsu_mem_stage (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] store_data_i,
   input  logic [4:0]  rd_i,
   input  logic [2:0]  funct3_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic        mem_to_reg_i,
   input  logic        reg_write_i,
   output logic        dbus_req_o,
   output logic        dbus_we_o,
   output logic [31:0] dbus_addr_o,
   output logic [31:0] dbus_wdata_o,
   output logic [3:0]  dbus_be_o,
   input  logic        dbus_gnt_i,
   input  logic        dbus_rvalid_i,
   input  logic [31:0] dbus_rdata_i,
   output logic        stall_o,
   output logic        misalign_o,
   output logic [31:0] wb_data_o,
   output logic [4:0]  rd_o,
   output logic        reg_write_o
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_R
   } state_t;

   state_t state;

   logic        is_load;
   logic        is_store;
   logic        mem_op;
   logic        bad_fmt;
   logic        illegal;
   logic        legal_mem;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [31:0] rdata_shifted;
   logic [31:0] load_data;
   logic        req_c;
   logic        stall_c;
   logic        unused_inputs;

   // A load is already identified by mem_read_i, so mem_to_reg_i adds nothing here.
   assign unused_inputs = mem_to_reg_i;

   // A simultaneous read and write request is treated as a load.
   assign is_load   = mem_read_i;
   assign is_store  = mem_write_i & ~mem_read_i;
   assign mem_op    = is_load | is_store;
   assign illegal   = mem_op & bad_fmt;
   assign legal_mem = mem_op & ~bad_fmt;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      bad_fmt = 1'b0;
      case (funct3_i)
         3'b001, 3'b101:         bad_fmt = addr_i[0];
         3'b010:                 bad_fmt = |addr_i[1:0];
         3'b011, 3'b110, 3'b111: bad_fmt = 1'b1;
         default:                bad_fmt = 1'b0;
      endcase
   end

   always_comb begin
      be_c    = 4'b1111;
      wdata_c = store_data_i;
      case (funct3_i[1:0])
         2'b00: begin
            be_c    = 4'b0001 << addr_i[1:0];
            wdata_c = {4{store_data_i[7:0]}};
         end
         2'b01: begin
            be_c    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{store_data_i[15:0]}};
         end
         default: begin
            be_c    = 4'b1111;
            wdata_c = store_data_i;
         end
      endcase
   end

   // Move the addressed byte/half down to bit 0, then extend by funct3[2].
   assign rdata_shifted = dbus_rdata_i >> {addr_i[1:0], 3'b000};

   always_comb begin
      load_data = rdata_shifted;
      case (funct3_i[1:0])
         2'b00:   load_data = funct3_i[2] ? {24'd0, rdata_shifted[7:0]}
                                          : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
         2'b01:   load_data = funct3_i[2] ? {16'd0, rdata_shifted[15:0]}
                                          : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
         default: load_data = rdata_shifted;
      endcase
   end

   // Stores finish on grant; loads keep the pipe frozen until read data returns.
   always_comb begin
      req_c   = 1'b0;
      stall_c = 1'b0;
      if (!rst_i) begin
         case (state)
            IDLE: begin
               if (legal_mem) begin
                  req_c   = 1'b1;
                  stall_c = is_load | ~dbus_gnt_i;
               end
            end
            REQ: begin
               req_c   = 1'b1;
               stall_c = is_load | ~dbus_gnt_i;
            end
            WAIT_R: begin
               stall_c = ~dbus_rvalid_i;
            end
            default: begin
               req_c   = 1'b0;
               stall_c = 1'b0;
            end
         endcase
      end
   end

   assign dbus_req_o   = req_c;
   assign dbus_we_o    = is_store;
   assign dbus_addr_o  = {addr_i[31:2], 2'b00};
   assign dbus_wdata_o = wdata_c;
   assign dbus_be_o    = be_c;
   assign stall_o      = stall_c;

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst_i) begin
         state       <= IDLE;
         wb_data_o   <= 32'd0;
         rd_o        <= 5'd0;
         reg_write_o <= 1'b0;
         misalign_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (legal_mem) begin
                  if (dbus_gnt_i) state <= is_load ? WAIT_R : IDLE;
                  else            state <= REQ;
               end
            end
            REQ: begin
               if (dbus_gnt_i) state <= is_load ? WAIT_R : IDLE;
            end
            WAIT_R: begin
               if (dbus_rvalid_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         misalign_o <= (state == IDLE) && illegal;

         // A stalled cycle leaves a bubble; data and destination hold.
         if (stall_c) begin
            reg_write_o <= 1'b0;
         end else begin
            wb_data_o   <= (state == WAIT_R) ? load_data : addr_i;
            rd_o        <= rd_i;
            reg_write_o <= reg_write_i & ~illegal;
         end
      end
   end

endmodule
